// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced panel-key front end that edits clock time or remind hour and commits it as a one-cycle load.
// Ports: clk_100Hz/reset (async, active-high) tick and reset; power_on low forces IDLE;
//        key_set/key_remind/key_up/key_down/key_cancel raw panel keys; cur_hour/cur_minute live time from timekeeper;
//        set_all_times 00 run / 01 load clock / 10 load remind; btn_time_set/btn_min_set load values;
//        editing/edit_field/blink display status.
// Option: define TIME_SET_AUTOREPEAT_EN for up/down auto-repeat while held.
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS = 2,
    parameter int unsigned TIMEOUT_TICKS  = 1000,
    parameter int unsigned BLINK_HALF     = 50,
    parameter int unsigned REMIND_DEFAULT = 10
) (
    input  logic       clk_100Hz,
    input  logic       reset,
    input  logic       power_on,
    input  logic       key_set,
    input  logic       key_remind,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_cancel,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    output logic [1:0] set_all_times,
    output logic [5:0] btn_time_set,
    output logic [5:0] btn_min_set,
    output logic       editing,
    output logic [1:0] edit_field,
    output logic       blink
);
    typedef enum logic [2:0] {IDLE, EDIT_HOUR, EDIT_MIN, EDIT_REMIND, COMMIT_CLOCK, COMMIT_REMIND} state_t;
    localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE_TICKS - 1);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_TICKS - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_HALF - 1);
    localparam logic [5:0]  REMIND_RST = 6'(REMIND_DEFAULT);
    // key order: {cancel, set, remind, up, down}
    logic [4:0]  raw, deb_q, press_q;
    logic [7:0]  db_cnt_q [5];
    logic [1:0]  rep;
    state_t      state_q;
    logic [5:0]  edit_h_q, edit_m_q, remind_q, edit_h_d, edit_m_d, hmin;
    logic [15:0] tmo_q;
    logic [7:0]  blink_cnt_q;
    logic        ev_cancel, ev_set, ev_remind, ev_up, ev_dn, up_p, dn_p, hi, any_key, tmo_done;
    assign raw = {key_cancel, key_set, key_remind, key_up, key_down};
    // A level is accepted only after DEBOUNCE_TICKS consecutive differing samples; press fires on accepted rise.
    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                press_q[i] <= 1'b0;
                if (raw[i] == deb_q[i]) db_cnt_q[i] <= '0;
                else if (db_cnt_q[i] == DB_LAST) begin
                    deb_q[i]    <= raw[i];
                    press_q[i]  <= raw[i];
                    db_cnt_q[i] <= '0;
                end else db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
            end
        end
    end
`ifdef TIME_SET_AUTOREPEAT_EN
    // First repeat after 50 held ticks, then every 10 (counter reloads to 40).
    logic [5:0] rep_cnt_q [2];
    logic [1:0] rep_q;
    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rep_q[i] <= 1'b0;
                if (!deb_q[i] || !editing) rep_cnt_q[i] <= '0;
                else if (rep_cnt_q[i] == 6'd49) begin
                    rep_q[i]     <= 1'b1;
                    rep_cnt_q[i] <= 6'd40;
                end else rep_cnt_q[i] <= rep_cnt_q[i] + 6'd1;
            end
        end
    end
    assign rep = rep_q;
`else
    assign rep = 2'b00;
`endif
    always_comb begin
        up_p      = press_q[1] | rep[1];
        dn_p      = press_q[0] | rep[0];
        hi        = |press_q[4:2];
        ev_cancel = press_q[4];
        ev_set    = press_q[3] & ~press_q[4];
        ev_remind = press_q[2] & ~|press_q[4:3];
        ev_up     = up_p & ~dn_p & ~hi;
        ev_dn     = dn_p & ~up_p & ~hi;
        any_key   = |press_q | |rep;
        tmo_done  = (tmo_q == TMO_LAST) & ~any_key;
        hmin      = (state_q == EDIT_REMIND) ? 6'd1 : 6'd0;
        edit_h_d  = ev_up ? ((edit_h_q >= 6'd23) ? hmin : edit_h_q + 6'd1)
                  : ev_dn ? ((edit_h_q <= hmin) ? 6'd23 : edit_h_q - 6'd1) : edit_h_q;
        edit_m_d  = ev_up ? ((edit_m_q >= 6'd59) ? 6'd0 : edit_m_q + 6'd1)
                  : ev_dn ? ((edit_m_q == 6'd0) ? 6'd59 : edit_m_q - 6'd1) : edit_m_q;
    end
    // Later assignments inside the case override the free-running timeout/blink defaults on field entry.
    always_ff @(posedge clk_100Hz or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            edit_h_q      <= '0;
            edit_m_q      <= '0;
            remind_q      <= REMIND_RST;
            tmo_q         <= '0;
            blink_cnt_q   <= '0;
            set_all_times <= 2'b00;
            btn_time_set  <= '0;
            btn_min_set   <= '0;
            editing       <= 1'b0;
            edit_field    <= 2'b00;
            blink         <= 1'b0;
        end else begin
            set_all_times <= 2'b00;
            tmo_q         <= any_key ? 16'd0 : tmo_q + 16'd1;
            blink_cnt_q   <= (blink_cnt_q == BLINK_LAST) ? 8'd0 : blink_cnt_q + 8'd1;
            blink         <= editing & ((blink_cnt_q == BLINK_LAST) ? ~blink : blink);
            if (!power_on) begin
                state_q    <= IDLE;
                editing    <= 1'b0;
                edit_field <= 2'b00;
                blink      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ev_set || ev_remind) begin
                            state_q     <= ev_set ? EDIT_HOUR : EDIT_REMIND;
                            edit_field  <= ev_set ? 2'b01 : 2'b11;
                            edit_h_q    <= ev_set ? ((cur_hour > 6'd23) ? 6'd0 : cur_hour) : remind_q;
                            edit_m_q    <= ev_set ? ((cur_minute > 6'd59) ? 6'd0 : cur_minute) : edit_m_q;
                            editing     <= 1'b1;
                            blink       <= 1'b1;
                            blink_cnt_q <= '0;
                            tmo_q       <= '0;
                        end
                    end
                    EDIT_HOUR, EDIT_MIN, EDIT_REMIND: begin
                        if (ev_cancel || tmo_done) begin
                            state_q    <= IDLE;
                            editing    <= 1'b0;
                            edit_field <= 2'b00;
                            blink      <= 1'b0;
                        end else if (ev_set && state_q == EDIT_HOUR) begin
                            state_q     <= EDIT_MIN;
                            edit_field  <= 2'b10;
                            blink       <= 1'b1;
                            blink_cnt_q <= '0;
                        end else if (ev_set) begin
                            state_q       <= (state_q == EDIT_MIN) ? COMMIT_CLOCK : COMMIT_REMIND;
                            set_all_times <= (state_q == EDIT_MIN) ? 2'b01 : 2'b10;
                            btn_time_set  <= edit_h_q;
                            btn_min_set   <= (state_q == EDIT_MIN) ? edit_m_q : btn_min_set;
                            remind_q      <= (state_q == EDIT_REMIND) ? edit_h_q : remind_q;
                            editing       <= 1'b0;
                            edit_field    <= 2'b00;
                            blink         <= 1'b0;
                        end else if (state_q == EDIT_MIN) edit_m_q <= edit_m_d;
                        else edit_h_q <= edit_h_d;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
